ca_seek_scheduler: RTL
======================

Name: ca_seek_scheduler

Overview:
- Sequencer for C/A code-phase search during acquisition.
- Steps the C/A upsampler through a programmed list of code-shift bins:
  - commands a seek to each bin;
  - waits for the seek to complete plus one pipeline cycle;
  - gates sample flow for a fixed dwell;
  - pulses bin boundaries to the correlator/accumulator.
- Sits between the acquisition controller and the upsampler's seek_en/seek_target/seeking/enable ports.

Parameters:
- CODE_LEN, 16800, upsampled samples per C/A period; shift domain is 0..CODE_LEN-1.
- SHIFT_W, 15, width of code-shift values.
- DWELL_W, 16, width of the dwell sample counter.
- TIMEOUT_CYC, 20000, seek watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; captures config and begins a sweep; ignored while busy.
- abort  in  1  returns to IDLE next cycle from any state.
- start_shift  in  SHIFT_W  first bin shift; captured at start.
- step  in  SHIFT_W  shift increment between bins; captured at start.
- num_bins  in  SHIFT_W  bins per sweep; 0 is treated as 1.
- dwell_len  in  DWELL_W  data_valid samples per bin; 0 is treated as 1.
- data_valid  in  1  sample-available strobe from the front end.
- seeking  in  1  upsampler seeking status.
- seek_en  out  1  to upsampler.
- seek_target  out  SHIFT_W  to upsampler.
- dwell_en  out  1  upsampler/accumulator enable; equals data_valid in DWELL, 0 otherwise.
- bin_start  out  1  1-cycle pulse on entry to DWELL.
- bin_done  out  1  1-cycle pulse in the cycle the last dwell sample is accepted.
- bin_index  out  SHIFT_W  index of the current bin, 0-based.
- busy  out  1  high in any state except IDLE.
- done  out  1  1-cycle pulse when the sweep completes.
- timeout  out  1  sticky watchdog flag (optional feature).

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE;
  - all outputs 0; seek_target=0; bin_index=0;
  - internal counters 0.
- States: IDLE, SEEK, SETTLE, DWELL, NEXT.
- IDLE:
  - On start, capture config.
  - start_shift >= CODE_LEN is reduced to 0.
  - step >= CODE_LEN is reduced modulo CODE_LEN by a single subtract; step < 2*CODE_LEN is guaranteed by the caller.
  - Go to SEEK.
- SEEK:
  - seek_en=1; seek_target holds the current bin shift.
  - Exit when seeking has been low for the cycle after seek_en rose; the first SEEK cycle never samples seeking.
  - Then go to SETTLE.
- SETTLE:
  - Exactly 1 cycle, seek_en=1. Covers the upsampler's 1-cycle enable pipe.
  - Then go to DWELL; bin_start pulses in the first DWELL cycle.
- DWELL:
  - seek_en=0; dwell_en=data_valid.
  - The counter increments on data_valid.
  - When the count reaches dwell_len on an accepted sample, bin_done pulses in that same cycle and the next state is NEXT.
- NEXT (1 cycle):
  - If bin_index == num_bins-1: done pulses, go to IDLE.
  - Else: bin_index+1; target = target+step; if the result >= CODE_LEN, subtract CODE_LEN (wrap). Go to SEEK.
- Arithmetic: the add is performed at SHIFT_W+1 bits, so there is no overflow before the wrap compare.
- abort has priority over every transition, including start in the same cycle:
  - next state IDLE;
  - seek_en, dwell_en and busy drop the next cycle;
  - no bin_done or done is emitted.
- start with abort in the same cycle: abort wins; the sweep does not start.
- A seek to the shift the upsampler already holds: seeking is low immediately, so SEEK lasts 2 cycles.
- data_valid outside DWELL is ignored. dwell_en never asserts outside DWELL.

Optional Feature:
- Macro: CA_SEEK_TIMEOUT_EN.
- With it defined:
  - A counter runs while in SEEK.
  - Reaching TIMEOUT_CYC sets timeout (sticky until reset or the next start) and forces IDLE without done.
- Without it: no counter; timeout tied 0; SEEK waits indefinitely.

Decomposition:
- Shared package holds:
  - CODE_LEN (16800);
  - the SHIFT_W localparam;
  - the state enumeration encoding (IDLE=0, SEEK=1, SETTLE=2, DWELL=3, NEXT=4).
- One natural sub-module: ca_shift_wrap_add, combinational modulo-CODE_LEN adder used for both step reduction and target advance.

Test Plan:
- start_shift=100, step=2, num_bins=3, dwell_len=4, seeking model clears after 5 cycles, data_valid=1 -> seek_target 100, 102, 104; three bin_start/bin_done pairs; bin_done after the 4th sample; done once; busy falls the next cycle.
- start_shift=16798, step=3, num_bins=2 -> second seek_target=1 (wrap).
- dwell_len=3, data_valid toggling 1010... -> dwell_en mirrors data_valid only in DWELL; bin_done coincides with the 3rd high data_valid.
- abort asserted mid-DWELL and mid-SEEK -> IDLE next cycle; seek_en/dwell_en=0; no done; a subsequent start runs a clean sweep.
- reset_n pulsed low asynchronously mid-sweep -> all outputs 0 immediately, without waiting for a clk edge.
- CA_SEEK_TIMEOUT_EN defined, TIMEOUT_CYC=50, seeking held high -> timeout=1 after 50 SEEK cycles; IDLE; no done.

Source files
------------

// File: rtl/ca_seek_scheduler_pkg.sv
// Shared constants and state encoding for the C/A code-phase seek scheduler.
package ca_seek_scheduler_pkg;

    localparam int CODE_LEN = 16800;  // upsampled samples per C/A period
    localparam int SHIFT_W  = 15;     // width of code-shift values
    localparam int DWELL_W  = 16;     // width of the dwell sample counter

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEEK   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DWELL  = 3'd3,
        ST_NEXT   = 3'd4
    } state_e;

endpackage

// File: rtl/ca_shift_wrap_add.sv
// Modulo-CODE_LEN adder for code shifts. Both operands are assumed to sum to
// less than 2*CODE_LEN, so a single conditional subtract is enough.
module ca_shift_wrap_add
    import ca_seek_scheduler_pkg::*;
(
    input  logic [SHIFT_W-1:0] a_i,
    input  logic [SHIFT_W-1:0] b_i,
    output logic [SHIFT_W-1:0] sum_o
);

    localparam logic [SHIFT_W:0] CODE_LEN_W = (SHIFT_W+1)'(CODE_LEN);

    logic [SHIFT_W:0] sum_full;
    logic [SHIFT_W:0] sum_wrap;

    // Add one bit wider so the wrap compare never sees an overflowed sum.
    always_comb begin
        sum_full = {1'b0, a_i} + {1'b0, b_i};
        sum_wrap = sum_full - CODE_LEN_W;
        sum_o    = (sum_full >= CODE_LEN_W) ? sum_wrap[SHIFT_W-1:0] : sum_full[SHIFT_W-1:0];
    end

endmodule

// File: rtl/ca_seek_scheduler.sv
// Steps the C/A upsampler through a list of code-shift bins: seek, settle one
// cycle, dwell for a fixed number of samples, then advance to the next bin.
// Optional seek watchdog: define CA_SEEK_TIMEOUT_EN to enable it.
module ca_seek_scheduler
    import ca_seek_scheduler_pkg::*;
`ifdef CA_SEEK_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYC = 20000
)
`endif
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [SHIFT_W-1:0] start_shift,
    input  logic [SHIFT_W-1:0] step,
    input  logic [SHIFT_W-1:0] num_bins,
    input  logic [DWELL_W-1:0] dwell_len,
    input  logic               data_valid,
    input  logic               seeking,
    output logic               seek_en,
    output logic [SHIFT_W-1:0] seek_target,
    output logic               dwell_en,
    output logic               bin_start,
    output logic               bin_done,
    output logic [SHIFT_W-1:0] bin_index,
    output logic               busy,
    output logic               done,
    output logic               timeout
);

    state_e             state_q, state_d;
    logic [SHIFT_W-1:0] target_q, target_d;
    logic [SHIFT_W-1:0] step_q, step_d;
    logic [SHIFT_W-1:0] nbins_q, nbins_d;
    logic [SHIFT_W-1:0] idx_q, idx_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               armed_q, armed_d;      // set after the first SEEK cycle
    logic               bin_start_q, bin_start_d;
    logic [SHIFT_W-1:0] step_red;
    logic [SHIFT_W-1:0] target_adv;

`ifdef CA_SEEK_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;
`endif

    // Step reduction at capture time: step < 2*CODE_LEN, so adding 0 and wrapping once suffices.
    ca_shift_wrap_add u_step_red (
        .a_i   (step),
        .b_i   ('0),
        .sum_o (step_red)
    );

    // Target advance between bins.
    ca_shift_wrap_add u_target_adv (
        .a_i   (target_q),
        .b_i   (step_q),
        .sum_o (target_adv)
    );

    // Next-state logic and Moore/Mealy outputs; abort overrides every transition.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        step_d      = step_q;
        nbins_d     = nbins_q;
        idx_d       = idx_q;
        dwell_d     = dwell_q;
        cnt_d       = cnt_q;
        armed_d     = armed_q;
        bin_start_d = 1'b0;
        seek_en     = 1'b0;
        dwell_en    = 1'b0;
        bin_done    = 1'b0;
        done        = 1'b0;
`ifdef CA_SEEK_TIMEOUT_EN
        to_cnt_d    = '0;
        timeout_d   = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    target_d = (start_shift >= SHIFT_W'(CODE_LEN)) ? '0 : start_shift;
                    step_d   = step_red;
                    nbins_d  = (num_bins == '0) ? SHIFT_W'(1) : num_bins;
                    dwell_d  = (dwell_len == '0) ? DWELL_W'(1) : dwell_len;
                    idx_d    = '0;
                    cnt_d    = '0;
                    armed_d  = 1'b0;
                    state_d  = ST_SEEK;
`ifdef CA_SEEK_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            ST_SEEK: begin
                seek_en = 1'b1;
                if (!armed_q) begin
                    armed_d = 1'b1;
                end else if (!seeking) begin
                    state_d = ST_SETTLE;
                end
`ifdef CA_SEEK_TIMEOUT_EN
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
`endif
            end
            ST_SETTLE: begin
                seek_en     = 1'b1;
                cnt_d       = '0;
                bin_start_d = 1'b1;
                state_d     = ST_DWELL;
            end
            ST_DWELL: begin
                dwell_en = data_valid;
                if (data_valid) begin
                    if (cnt_q + DWELL_W'(1) == dwell_q) begin
                        bin_done = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_NEXT;
                    end else begin
                        cnt_d = cnt_q + DWELL_W'(1);
                    end
                end
            end
            ST_NEXT: begin
                if (idx_q == nbins_q - SHIFT_W'(1)) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    idx_d    = idx_q + SHIFT_W'(1);
                    target_d = target_adv;
                    armed_d  = 1'b0;
                    state_d  = ST_SEEK;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d     = ST_IDLE;
            target_d    = target_q;
            step_d      = step_q;
            nbins_d     = nbins_q;
            idx_d       = idx_q;
            dwell_d     = dwell_q;
            bin_start_d = 1'b0;
            bin_done    = 1'b0;
            done        = 1'b0;
`ifdef CA_SEEK_TIMEOUT_EN
            timeout_d   = timeout_q;
`endif
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            target_q    <= '0;
            step_q      <= '0;
            nbins_q     <= '0;
            idx_q       <= '0;
            dwell_q     <= '0;
            cnt_q       <= '0;
            armed_q     <= 1'b0;
            bin_start_q <= 1'b0;
`ifdef CA_SEEK_TIMEOUT_EN
            to_cnt_q    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            step_q      <= step_d;
            nbins_q     <= nbins_d;
            idx_q       <= idx_d;
            dwell_q     <= dwell_d;
            cnt_q       <= cnt_d;
            armed_q     <= armed_d;
            bin_start_q <= bin_start_d;
`ifdef CA_SEEK_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign seek_target = target_q;
    assign bin_index   = idx_q;
    assign bin_start   = bin_start_q;
    assign busy        = (state_q != ST_IDLE);
`ifdef CA_SEEK_TIMEOUT_EN
    assign timeout     = timeout_q;
`else
    assign timeout     = 1'b0;
`endif

endmodule
